// File: rtl/parity_serial_rx.sv
// parity_serial_rx: receive end of the XOR-parity serial link. Deserialises
// start / data (LSB first) / parity / stop frames from an asynchronous line
// and reports each word together with its parity and framing status.
`timescale 1ns/1ps
module parity_serial_rx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int ODD_PARITY   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LP_CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] LP_IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             LP_ODD      = (ODD_PARITY != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity mismatch: accumulated data XOR, received parity bit and the
    // polarity selection must combine to zero for a clean frame.
    function automatic logic f_parity_err(input logic acc, input logic sample);
        return acc ^ sample ^ LP_ODD;
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_acc;
    logic                 r_perr;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_data_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_busy;
    logic                 w_mid_start;
    logic                 w_data_tick;
    logic                 w_perr_load;
    logic                 w_frame_done;

    // Two-flop synchroniser for the asynchronous serial line (idle high).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; every sampling point is the middle of a bit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!r_rx_s) w_state_nxt = ST_START;
                else         w_state_nxt = ST_IDLE;
            end
            ST_START: begin
                if (w_mid_start) w_state_nxt = r_rx_s ? ST_IDLE : ST_DATA;
                else             w_state_nxt = ST_START;
            end
            ST_DATA: begin
                if (w_data_tick && (r_idx == LP_IDX_LAST)) w_state_nxt = ST_PARITY;
                else                                       w_state_nxt = ST_DATA;
            end
            ST_PARITY: begin
                if (w_perr_load) w_state_nxt = ST_STOP;
                else             w_state_nxt = ST_PARITY;
            end
            ST_STOP: begin
                // Leaving at mid-stop lets a back-to-back start edge be seen.
                if (w_frame_done) w_state_nxt = ST_IDLE;
                else              w_state_nxt = ST_STOP;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output decode: per-state sampling strobes.
    always_comb begin
        w_mid_start  = 1'b0;
        w_data_tick  = 1'b0;
        w_perr_load  = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_START:  w_mid_start  = (r_cnt == LP_CNT_MID);
            ST_DATA:   w_data_tick  = (r_cnt == LP_CNT_LAST);
            ST_PARITY: w_perr_load  = (r_cnt == LP_CNT_LAST);
            ST_STOP:   w_frame_done = (r_cnt == LP_CNT_LAST);
            default:   w_mid_start  = 1'b0;
        endcase
    end

    // Bit-period counter: held at zero in IDLE, realigned at mid start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if ((r_state == ST_IDLE) || w_mid_start) begin
            r_cnt <= '0;
        end else if (r_cnt == LP_CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Data shift register, bit index and running parity accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_shift <= '0;
            r_acc   <= 1'b0;
            r_perr  <= 1'b0;
        end else if ((r_state == ST_IDLE) || w_mid_start) begin
            r_idx <= '0;
            r_acc <= 1'b0;
        end else if (w_data_tick) begin
            // LSB arrives first, so shifting in from the top leaves bit i at [i].
            r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            r_acc   <= r_acc ^ r_rx_s;
            r_idx   <= r_idx + IDX_W'(1);
        end else if (w_perr_load) begin
            r_perr <= f_parity_err(r_acc, r_rx_s);
        end else begin
            r_acc <= r_acc;
        end
    end

    // Registered outputs: word and status update together with the valid pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_data_valid <= w_frame_done;
            r_busy       <= (w_state_nxt != ST_IDLE);
            if (w_frame_done) begin
                r_data_out   <= r_shift;
                r_parity_err <= r_perr;
                r_frame_err  <= ~r_rx_s;
            end else begin
                r_data_out   <= r_data_out;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_parity_serial_rx.sv
// Self-checking bench for parity_serial_rx with a scoreboard of expected frames.
`timescale 1ns/1ps
module tb_parity_serial_rx;

    localparam int CPB = 4;
    localparam int DB  = 8;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          rx;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          parity_err;
    logic          frame_err;
    logic          busy;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pulses = 0;
    int   n_exp    = 0;

    parity_serial_rx #(
        .DATA_BITS   (DB),
        .CLKS_PER_BIT(CPB),
        .ODD_PARITY  (0)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data_out  (data_out),
        .data_valid(data_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        exp_t e;
        e.d  = d;
        e.pe = (^d) ^ p;
        e.fe = ~s;
        exp_q.push_back(e);
        n_exp++;
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
        rx = 1'b1;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick(1);
            k++;
        end
        check_value({tag, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
        tick(2 * CPB);
        check_value({tag, "_busy"}, busy, 1'b0);
        check_value({tag, "_pulses"}, n_pulses, n_exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_dout"}, data_out, 8'h00);
        check_value({tag, "_dv"}, data_valid, 1'b0);
        check_value({tag, "_perr"}, parity_err, 1'b0);
        check_value({tag, "_ferr"}, frame_err, 1'b0);
        check_value({tag, "_busy"}, busy, 1'b0);
    endtask

    // Scoreboard monitor: every data_valid pulse pops and compares one frame.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                check_value("unexp_pulse", data_valid, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check_value("dout", data_out, mon_e.d);
                check_value("perr", parity_err, mon_e.pe);
                check_value("ferr", frame_err, mon_e.fe);
            end
        end
    end

    initial begin
        logic [7:0] v;
        rst_n = 1'b0;
        rx    = 1'b1;

        // 1: reset state and quiet line afterwards
        tick(3);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick(50);
        check_value("rst_quiet", n_pulses, 0);

        // 2: clean even-parity frame
        send_frame(8'hA5, 1'b0, 1'b1);
        drain("even");

        // 3: wrong parity, then correct parity
        send_frame(8'h01, 1'b0, 1'b1);
        drain("perr1");
        send_frame(8'h03, 1'b0, 1'b1);
        drain("perr0");

        // 4: stop bit low
        send_frame(8'hFF, 1'b0, 1'b0);
        drain("ferr");

        // 5: one-cycle glitch, then back-to-back frames
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(12);
        check_value("glitch_busy", busy, 1'b0);
        check_value("glitch_pulses", n_pulses, n_exp);
        send_frame(8'h3C, ^8'h3C, 1'b1);
        send_frame(8'hC3, ^8'hC3, 1'b1);
        drain("b2b");

        // 6: reset in the middle of the data bits
        v = 8'h55;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(v[i]);
        rx = v[4];
        tick(2);
        rst_n = 1'b0;
        rx    = 1'b1;
        tick(3);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        tick(20);
        check_value("midrst_pulses", n_pulses, n_exp);
        check_value("midrst_busy", busy, 1'b0);
        send_frame(8'h55, ^8'h55, 1'b1);
        drain("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
